// File: rtl/alu_nibble_sequencer.sv
// Sequencer that runs one wide ALU operation as NIBBLES chained 4-bit passes through
// an external combinational ALU slice, assembling the wide result and final carry.
module alu_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic [3:0]             op_s,
   input  logic                   op_m,
   input  logic                   carry_in,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   carry_out,
   output logic                   zero,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic [3:0]             alu_s,
   output logic                   alu_m,
   output logic                   alu_pin,
   input  logic [3:0]             alu_r,
   input  logic                   alu_cout
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_lat, b_lat;
   logic [W-1:0]  result_nxt;
   logic          carry;
   logic          accept;
   logic          last;

   assign ready  = (state != RUN);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);
   assign accept = ready && start;
   assign last   = (idx == LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Slice drive is gated to RUN so the ALU sees zeros whenever no pass is in flight.
   always_comb begin
      alu_a      = '0;
      alu_b      = '0;
      alu_pin    = 1'b0;
      result_nxt = result;
      if (state == RUN) begin
         alu_a   = a_lat[4*int'(idx) +: 4];
         alu_b   = b_lat[4*int'(idx) +: 4];
         alu_pin = carry;
         result_nxt[4*int'(idx) +: 4] = alu_r;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_lat     <= '0;
         b_lat     <= '0;
         alu_s     <= '0;
         alu_m     <= 1'b0;
         carry     <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         zero      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_lat     <= op_a;
            b_lat     <= op_b;
            alu_s     <= op_s;
            alu_m     <= op_m;
            carry     <= carry_in;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
         end else if (state == RUN) begin
            result <= result_nxt;
            carry  <= alu_cout;
            if (last) begin
               carry_out <= alu_cout;
               zero      <= (result_nxt == '0);
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench for alu_nibble_sequencer with an adder model standing in for the ALU slice.
module tb_alu_nibble_sequencer;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic [3:0]    op_s = '0;
   logic          op_m = 1'b0;
   logic          carry_in = 1'b0;
   logic          ready, busy, done, carry_out, zero;
   logic [W-1:0]  result;
   logic [3:0]    alu_a, alu_b, alu_s, alu_r;
   logic          alu_m, alu_pin, alu_cout;

   alu_nibble_sequencer #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
      .op_s(op_s), .op_m(op_m), .carry_in(carry_in), .ready(ready), .busy(busy),
      .done(done), .result(result), .carry_out(carry_out), .zero(zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_pin(alu_pin),
      .alu_r(alu_r), .alu_cout(alu_cout)
   );

   assign {alu_cout, alu_r} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_pin};

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         z;
   } exp_t;

   exp_t       expq[$];
   int         checks = 0;
   int         errors = 0;
   int         done_cnt = 0;
   int         busy_cnt = 0;
   int         pin_n = 0;
   logic [3:0] pin_log = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: logs the carry presented to the slice and scores every done pulse.
   always @(negedge clk) begin
      if (rst_n && busy) begin
         busy_cnt++;
         if (pin_n < 4) pin_log[pin_n] = alu_pin;
         pin_n++;
      end
      if (rst_n && done) begin
         exp_t e;
         done_cnt++;
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done actual=result %0h required=no done", result);
         end else begin
            e = expq.pop_front();
            chk("result", 32'(result), 32'(e.r));
            chk("carry_out", 32'(carry_out), 32'(e.c));
            chk("zero", 32'(zero), 32'(e.z));
            chk("ready_in_done", 32'(ready), 32'd1);
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] er, input logic ec);
      @(negedge clk);
      op_a = a; op_b = b; carry_in = cin; start = 1'b1;
      expq.push_back('{r: er, c: ec, z: (er == '0)});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n;
      n = 0;
      while (done_cnt < target && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt < target) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=%0d dones required=%0d", name, done_cnt, target);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int target;
      // Test 1: reset and idle
      repeat (2) begin
         @(negedge clk);
         chk("rst_ready", 32'(ready), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_result", 32'(result), 32'd0);
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ready", 32'(ready), 32'd1);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_result", 32'(result), 32'd0);
         chk("idle_cout", 32'(carry_out), 32'd0);
         chk("idle_zero", 32'(zero), 32'd0);
      end

      // Test 2: carry ripples through three nibbles
      busy_cnt = 0; pin_n = 0;
      issue(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);
      wait_done(1, "t2");
      chk("t2_busy_cycles", 32'(busy_cnt), 32'd4);
      chk("t2_pin_seq", 32'(pin_log), 32'b1110);

      // Test 3: overflow to zero
      issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      wait_done(2, "t3");

      // Test 4: start held through RUN is ignored, accepted again in DONE
      @(negedge clk);
      op_a = 16'h1111; op_b = 16'h2222; carry_in = 1'b0; start = 1'b1;
      expq.push_back('{r: 16'h3333, c: 1'b0, z: 1'b0});
      @(negedge clk);
      op_a = 16'h1234; op_b = 16'h1111;
      expq.push_back('{r: 16'h2345, c: 1'b0, z: 1'b0});
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t4_first_done_seen", 32'(done), 32'd1);
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
      chk("t4_second_latency", 32'(n), 32'd5);
      wait_done(4, "t4");

      // Test 5: reset mid-RUN aborts without a done pulse
      target = done_cnt;
      op_a = 16'h1234; op_b = 16'h4321; carry_in = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("t5_partial_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_abort_ready", 32'(ready), 32'd1);
      chk("t5_abort_busy", 32'(busy), 32'd0);
      chk("t5_abort_result", 32'(result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("t5_no_done", 32'(done_cnt), 32'(target));
      issue(16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0);
      wait_done(target + 1, "t5");

      // Test 6: operand changes after acceptance do not leak in
      op_s = 4'h9; op_m = 1'b1;
      issue(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0);
      op_a = 16'hFFFF; op_b = 16'hFFFF; op_s = 4'h2; op_m = 1'b0;
      wait_done(target + 2, "t6");
      chk("t6_alu_s_held", 32'(alu_s), 32'h9);
      chk("t6_alu_m_held", 32'(alu_m), 32'd1);
      chk("t6_alu_a_idle", 32'(alu_a), 32'd0);
      chk("t6_result_held", 32'(result), 32'h0100);

      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
